// File: rtl/gt_reset_sequencer_if.sv
// Status/control bundle between the GT reset sequencer and the logic that observes it.
// The slave modport is taken by the sequencer; the master modport is taken by the lane/control side.
interface gt_reset_sequencer_if #(
    parameter int NUM_CH    = 2,
    parameter int MAX_RETRY = 3
);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [NUM_CH-1:0]  LANE_UP;
    logic               RETRIGGER;
    logic               RESET_GT;
    logic               DONE;
    logic               FAIL;
    logic [RETRY_W-1:0] RETRY_CNT;
    logic [2:0]         STATE;

    modport master (
        output LANE_UP,
        output RETRIGGER,
        input  RESET_GT,
        input  DONE,
        input  FAIL,
        input  RETRY_CNT,
        input  STATE
    );

    modport slave (
        input  LANE_UP,
        input  RETRIGGER,
        output RESET_GT,
        output DONE,
        output FAIL,
        output RETRY_CNT,
        output STATE
    );
endinterface

// File: rtl/gt_reset_sequencer.sv
// GT reset sequencer: a train of reset pulses, then a wait for all lanes to stay up,
// with bounded retries, a sticky FAILED state, and restart on lane loss or retrigger.
module gt_reset_sequencer #(
    parameter int NUM_CH       = 2,
    parameter int PULSE_CYC    = 50,
    parameter int GAP_CYC      = 50,
    parameter int NUM_PULSES   = 2,
    parameter int STABLE_CYC   = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int MAX_RETRY    = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    gt_reset_sequencer_if.slave    seq
);
    localparam int MAX_PG  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_PG > LOCK_TIMEOUT) ? MAX_PG : LOCK_TIMEOUT;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int STB_W   = $clog2(STABLE_CYC + 1);
    localparam int PIDX_W  = $clog2(NUM_PULSES + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0]   STABLE_LAST  = STB_W'(STABLE_CYC - 1);
    localparam logic [PIDX_W-1:0]  PIDX_LAST    = PIDX_W'(NUM_PULSES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_PULSE   = 3'd0,
        ST_GAP     = 3'd1,
        ST_WAIT_UP = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAILED  = 3'd4
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cyc_cnt_r;
    logic [STB_W-1:0]   stable_cnt_r;
    logic [PIDX_W-1:0]  pulse_idx_r;
    logic [RETRY_W-1:0] retry_cnt_r;
    logic               gt_reset_r;
    logic               done_r;
    logic               fail_r;
    logic               all_up_s;

    assign all_up_s = &seq.LANE_UP;

    // Sequencer FSM; gt_reset_r always tracks "next state is PULSE" so it lines up with state_r.
    always_ff @(posedge CLK) begin
        if (RESET || seq.RETRIGGER) begin
            state_r      <= ST_PULSE;
            cyc_cnt_r    <= '0;
            stable_cnt_r <= '0;
            pulse_idx_r  <= '0;
            retry_cnt_r  <= '0;
            gt_reset_r   <= 1'b1;
            done_r       <= 1'b0;
            fail_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_PULSE: begin
                    if (cyc_cnt_r == PULSE_LAST) begin
                        cyc_cnt_r  <= '0;
                        gt_reset_r <= 1'b0;
                        if (pulse_idx_r == PIDX_LAST) begin
                            state_r      <= ST_WAIT_UP;
                            pulse_idx_r  <= '0;
                            stable_cnt_r <= '0;
                        end else begin
                            state_r <= ST_GAP;
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cyc_cnt_r == GAP_LAST) begin
                        cyc_cnt_r   <= '0;
                        state_r     <= ST_PULSE;
                        gt_reset_r  <= 1'b1;
                        pulse_idx_r <= pulse_idx_r + PIDX_W'(1);
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT_UP: begin
                    // Lock is tested first so it wins over a coincident timeout.
                    if (all_up_s && (stable_cnt_r == STABLE_LAST)) begin
                        state_r      <= ST_LOCKED;
                        done_r       <= 1'b1;
                        cyc_cnt_r    <= '0;
                        stable_cnt_r <= '0;
                    end else if (cyc_cnt_r == TIMEOUT_LAST) begin
                        cyc_cnt_r    <= '0;
                        stable_cnt_r <= '0;
                        pulse_idx_r  <= '0;
                        if (retry_cnt_r < RETRY_MAX) begin
                            state_r     <= ST_PULSE;
                            gt_reset_r  <= 1'b1;
                            retry_cnt_r <= retry_cnt_r + RETRY_W'(1);
                        end else begin
                            state_r <= ST_FAILED;
                            fail_r  <= 1'b1;
                        end
                    end else begin
                        cyc_cnt_r    <= cyc_cnt_r + CNT_W'(1);
                        stable_cnt_r <= all_up_s ? (stable_cnt_r + STB_W'(1)) : '0;
                    end
                end
                ST_LOCKED: begin
                    if (!all_up_s) begin
                        state_r      <= ST_PULSE;
                        gt_reset_r   <= 1'b1;
                        done_r       <= 1'b0;
                        retry_cnt_r  <= '0;
                        pulse_idx_r  <= '0;
                        cyc_cnt_r    <= '0;
                        stable_cnt_r <= '0;
                    end else begin
                        done_r <= 1'b1;
                    end
                end
                ST_FAILED: begin
                    gt_reset_r <= 1'b0;
                    fail_r     <= 1'b1;
                end
                default: begin
                    state_r      <= ST_PULSE;
                    cyc_cnt_r    <= '0;
                    stable_cnt_r <= '0;
                    pulse_idx_r  <= '0;
                    retry_cnt_r  <= '0;
                    gt_reset_r   <= 1'b1;
                    done_r       <= 1'b0;
                    fail_r       <= 1'b0;
                end
            endcase
        end
    end

    assign seq.RESET_GT  = RESET | gt_reset_r;
    assign seq.DONE      = done_r;
    assign seq.FAIL      = fail_r;
    assign seq.RETRY_CNT = retry_cnt_r;
    assign seq.STATE     = state_r;

endmodule

// File: tb/tb_gt_reset_sequencer.sv
// Directed bench for gt_reset_sequencer with a short lock timeout and two retries.
module tb_gt_reset_sequencer;
    logic CLK;
    logic RESET;
    int   errors;
    int   checks;
    int   cyc;

    gt_reset_sequencer_if #(.NUM_CH(2), .MAX_RETRY(2)) seq_if ();

    gt_reset_sequencer #(
        .NUM_CH      (2),
        .PULSE_CYC   (50),
        .GAP_CYC     (50),
        .NUM_PULSES  (2),
        .STABLE_CYC  (16),
        .LOCK_TIMEOUT(300),
        .MAX_RETRY   (2)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .seq  (seq_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk_gt(input string tag, input int c, input logic [31:0] exp);
        go_to(c);
        chk(tag, {31'd0, seq_if.RESET_GT}, exp);
    endtask

    task automatic chk_st(input string tag, input int c, input logic [31:0] exp);
        go_to(c);
        chk(tag, {29'd0, seq_if.STATE}, exp);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        RESET  = 1'b1;
        seq_if.LANE_UP   = 2'b00;
        seq_if.RETRIGGER = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_gt",    {31'd0, seq_if.RESET_GT}, 32'd1);
        chk("rst_done",  {31'd0, seq_if.DONE},     32'd0);
        chk("rst_fail",  {31'd0, seq_if.FAIL},     32'd0);
        chk("rst_state", {29'd0, seq_if.STATE},    32'd0);
        chk("rst_retry", {30'd0, seq_if.RETRY_CNT}, 32'd0);

        // Test 1: default pulse train with lanes down
        RESET = 1'b0;
        cyc   = 0;
        chk_gt("t1_gt_c0",   0,   32'd1);
        chk_gt("t1_gt_c49",  49,  32'd1);
        chk_gt("t1_gt_c50",  50,  32'd0);
        chk_st("t1_st_c50",  50,  32'd1);
        chk_gt("t1_gt_c99",  99,  32'd0);
        chk_gt("t1_gt_c100", 100, 32'd1);
        chk_gt("t1_gt_c149", 149, 32'd1);
        chk_gt("t1_gt_c150", 150, 32'd0);
        chk_st("t1_st_c150", 150, 32'd2);

        // Test 3: lanes stay down, two retries then FAILED
        chk_st("t3_st_c449", 449, 32'd2);
        chk("t3_retry_c449", {30'd0, seq_if.RETRY_CNT}, 32'd0);
        chk_gt("t3_gt_c450", 450, 32'd1);
        chk("t3_retry_c450", {30'd0, seq_if.RETRY_CNT}, 32'd1);
        chk_gt("t3_gt_c499", 499, 32'd1);
        chk_gt("t3_gt_c500", 500, 32'd0);
        chk_st("t3_st_c600", 600, 32'd2);
        chk_st("t3_st_c899", 899, 32'd2);
        chk_gt("t3_gt_c900", 900, 32'd1);
        chk("t3_retry_c900", {30'd0, seq_if.RETRY_CNT}, 32'd2);
        chk_st("t3_st_c1349", 1349, 32'd2);
        chk("t3_fail_c1349", {31'd0, seq_if.FAIL}, 32'd0);
        chk_st("t3_st_c1350", 1350, 32'd4);
        chk("t3_fail_c1350", {31'd0, seq_if.FAIL}, 32'd1);
        chk("t3_gt_c1350",   {31'd0, seq_if.RESET_GT}, 32'd0);
        chk("t3_done_c1350", {31'd0, seq_if.DONE}, 32'd0);
        chk_st("t3_st_c1400", 1400, 32'd4);
        chk("t3_gt_c1400", {31'd0, seq_if.RESET_GT}, 32'd0);

        // Test 6a: retrigger out of FAILED
        seq_if.RETRIGGER = 1'b1;
        tick();
        seq_if.RETRIGGER = 1'b0;
        cyc = 0;
        chk("t6a_fail",  {31'd0, seq_if.FAIL},      32'd0);
        chk("t6a_state", {29'd0, seq_if.STATE},     32'd0);
        chk("t6a_gt",    {31'd0, seq_if.RESET_GT},  32'd1);
        chk("t6a_retry", {30'd0, seq_if.RETRY_CNT}, 32'd0);

        // Test 2: lanes up from cycle 200, lock 16 cycles later
        go_to(200);
        seq_if.LANE_UP = 2'b11;
        chk_st("t2_st_c215", 215, 32'd2);
        chk("t2_done_c215", {31'd0, seq_if.DONE}, 32'd0);
        chk_st("t2_st_c216", 216, 32'd3);
        chk("t2_done_c216", {31'd0, seq_if.DONE}, 32'd1);
        chk("t2_gt_c216",   {31'd0, seq_if.RESET_GT}, 32'd0);
        chk_gt("t2_gt_c230", 230, 32'd0);

        // Test 5: one-cycle drop of lane 1 while locked
        seq_if.LANE_UP = 2'b01;
        tick();
        seq_if.LANE_UP = 2'b11;
        cyc = 0;
        chk("t5_done",  {31'd0, seq_if.DONE},      32'd0);
        chk("t5_state", {29'd0, seq_if.STATE},     32'd0);
        chk("t5_retry", {30'd0, seq_if.RETRY_CNT}, 32'd0);
        chk("t5_gt_c0", {31'd0, seq_if.RESET_GT},  32'd1);
        tick();
        seq_if.LANE_UP = 2'b00;
        chk_gt("t5_gt_c49", 49, 32'd1);
        chk_gt("t5_gt_c50", 50, 32'd0);

        // Test 4: single-cycle glitch at 210 restarts the stable count
        go_to(200);
        seq_if.LANE_UP = 2'b11;
        go_to(210);
        seq_if.LANE_UP = 2'b01;
        go_to(211);
        seq_if.LANE_UP = 2'b11;
        chk_st("t4_st_c216", 216, 32'd2);
        chk("t4_done_c216", {31'd0, seq_if.DONE}, 32'd0);
        chk_st("t4_st_c226", 226, 32'd2);
        chk_st("t4_st_c227", 227, 32'd3);
        chk("t4_done_c227", {31'd0, seq_if.DONE}, 32'd1);

        // Retrigger from LOCKED, then RESET at WAIT_UP cycle 20
        go_to(230);
        seq_if.RETRIGGER = 1'b1;
        tick();
        seq_if.RETRIGGER = 1'b0;
        seq_if.LANE_UP   = 2'b00;
        cyc = 0;
        chk("t6_relock_done", {31'd0, seq_if.DONE}, 32'd0);
        chk_st("t6b_st_c170", 170, 32'd2);
        chk("t6b_gt_pre", {31'd0, seq_if.RESET_GT}, 32'd0);
        RESET = 1'b1;
        #1;
        chk("t6b_gt_same_cycle", {31'd0, seq_if.RESET_GT}, 32'd1);
        tick();
        chk("t6b_state_rst", {29'd0, seq_if.STATE}, 32'd0);
        tick();
        RESET = 1'b0;
        cyc = 0;
        chk_gt("t6b_gt_c0", 0, 32'd1);

        // Retrigger during PULSE restarts the pulse timing
        go_to(30);
        seq_if.RETRIGGER = 1'b1;
        tick();
        seq_if.RETRIGGER = 1'b0;
        cyc = 0;
        chk_gt("trg_gt_c19", 19, 32'd1);
        chk_gt("trg_gt_c49", 49, 32'd1);
        chk_st("trg_st_c50", 50, 32'd1);
        chk_gt("trg_gt_c100", 100, 32'd1);
        chk_st("trg_st_c150", 150, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
